// File: rtl/margin_topk.sv
// margin_topk: streaming uncertainty ranker for active-learning sample selection.
//
// Each accepted beat carries NUM_CLASSES unsigned class scores for one sample.
// Stage 1 registers the top score, the runner-up score and the sample index.
// Stage 2 turns them into an uncertainty key:
//   MODE = 0: margin key = top - runner-up
//   MODE = 1: least-confidence key = top
// It then inserts the key into a K-entry list kept sorted ascending by key.
// Rank 0 is the most uncertain sample. The list is readable through a
// registered random-access port.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            pulse: clear list, counter and err, open a run (any state)
//   busy             run in progress (ACCUM or DRAIN)
//   done             one-cycle pulse when list contents are final
//   err              sticky: a beat arrived after the index space was exhausted
//   in_valid/ready   beat handshake; in_ready is high only in ACCUM
//   in_last          last sample of the run
//   in_scores        class c at bits [c*SCORE_W +: SCORE_W]
//   rd_addr          rank to read, 0 = most uncertain
//   rd_idx/key/vld   registered readout of that rank (one-cycle latency)
module margin_topk #(
    parameter int unsigned NUM_CLASSES = 4,
    parameter int unsigned SCORE_W     = 16,
    parameter int unsigned K           = 10,
    parameter int unsigned IDX_W       = 13,
    parameter int unsigned MODE        = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_last,
    input  logic [NUM_CLASSES*SCORE_W-1:0]       in_scores,
    input  logic [((K > 1) ? $clog2(K) : 1)-1:0] rd_addr,
    output logic [IDX_W-1:0]                     rd_idx,
    output logic [SCORE_W-1:0]                   rd_key,
    output logic                                 rd_vld
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   drain_q, drain_d;
    logic   busy_d, done_d, ready_d;
    logic   clear_c;
    logic   accept_c;

    logic [CNT_W-1:0]   cnt_q;
    logic               s1_vld_q;
    logic [SCORE_W-1:0] s1_top_q, s1_sec_q;
    logic [IDX_W-1:0]   s1_idx_q;
    logic [SCORE_W-1:0] top_c, sec_c;

    logic [SCORE_W-1:0] key_q [K];
    logic [IDX_W-1:0]   idx_q [K];
    logic [K-1:0]       vld_q;
    logic [SCORE_W-1:0] key_d [K];
    logic [IDX_W-1:0]   idx_d [K];
    logic [K-1:0]       vld_d;
    logic [SCORE_W-1:0] new_key_c;
    logic [K-1:0]       lt_c;

    // A start in the same cycle as a beat wins: the beat is dropped.
    assign accept_c = in_valid && in_ready && !start;

    // FSM state register and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            drain_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            busy     <= busy_d;
            done     <= done_d;
            in_ready <= ready_d;
        end
    end

    // FSM next state; status outputs are decoded from the next state so they
    // line up with the state they describe.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        clear_c = 1'b0;
        case (state_q)
            S_IDLE: begin
            end
            S_ACCUM: begin
                if (accept_c && in_last) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                // Two cycles: lets the last beat clear both pipeline stages.
                if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (start) begin
            state_d = S_ACCUM;
            clear_c = 1'b1;
        end
        busy_d  = (state_d == S_ACCUM) || (state_d == S_DRAIN);
        ready_d = (state_d == S_ACCUM);
        done_d  = (state_d == S_DONE);
    end

    // Top and runner-up score. A duplicate maximum becomes the runner-up,
    // which gives margin 0.
    always_comb begin
        top_c = in_scores[SCORE_W-1:0];
        sec_c = '0;
        for (int c = 1; c < int'(NUM_CLASSES); c++) begin
            if (in_scores[c*SCORE_W +: SCORE_W] > top_c) begin
                sec_c = top_c;
                top_c = in_scores[c*SCORE_W +: SCORE_W];
            end else if (in_scores[c*SCORE_W +: SCORE_W] > sec_c) begin
                sec_c = in_scores[c*SCORE_W +: SCORE_W];
            end
        end
    end

    // Sample counter, overflow flag and stage-1 pipeline register.
    // The counter saturates at 2^IDX_W. Beats arriving after that set err
    // and are not forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            err      <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_top_q <= '0;
            s1_sec_q <= '0;
            s1_idx_q <= '0;
        end else if (clear_c) begin
            cnt_q    <= '0;
            err      <= 1'b0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= 1'b0;
            if (accept_c) begin
                if (cnt_q == CNT_MAX) begin
                    err <= 1'b1;
                end else begin
                    cnt_q    <= cnt_q + CNT_W'(1);
                    s1_vld_q <= 1'b1;
                    s1_top_q <= top_c;
                    s1_sec_q <= sec_c;
                    s1_idx_q <= cnt_q[IDX_W-1:0];
                end
            end
        end
    end

    assign new_key_c = (MODE == 0) ? (s1_top_q - s1_sec_q) : s1_top_q;

    // Per-rank "new key goes at or before this slot". Strict less-than keeps
    // earlier samples ahead of later ones with an equal key. Because the list
    // is sorted with valid entries first, this vector is thermometer shaped.
    always_comb begin
        for (int i = 0; i < int'(K); i++) begin
            lt_c[i] = !vld_q[i] || (new_key_c < key_q[i]);
        end
    end

    // Parallel insert. The first slot with lt set takes the new entry. Every
    // later slot takes its upper neighbour, and the old rank K-1 falls off.
    always_comb begin
        key_d = key_q;
        idx_d = idx_q;
        vld_d = vld_q;
        if (s1_vld_q) begin
            if (lt_c[0]) begin
                key_d[0] = new_key_c;
                idx_d[0] = s1_idx_q;
                vld_d[0] = 1'b1;
            end
            for (int i = 1; i < int'(K); i++) begin
                if (lt_c[i]) begin
                    if (lt_c[i-1]) begin
                        key_d[i] = key_q[i-1];
                        idx_d[i] = idx_q[i-1];
                        vld_d[i] = vld_q[i-1];
                    end else begin
                        key_d[i] = new_key_c;
                        idx_d[i] = s1_idx_q;
                        vld_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Ranked list storage. A start clears it and overrides any insert in the
    // same cycle, so beats still in flight are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(K); i++) begin
                key_q[i] <= '1;
                idx_q[i] <= '1;
            end
            vld_q <= '0;
        end else if (clear_c) begin
            for (int i = 0; i < int'(K); i++) begin
                key_q[i] <= '1;
                idx_q[i] <= '1;
            end
            vld_q <= '0;
        end else begin
            for (int i = 0; i < int'(K); i++) begin
                key_q[i] <= key_d[i];
                idx_q[i] <= idx_d[i];
            end
            vld_q <= vld_d;
        end
    end

    // Registered read port. Out-of-range ranks read as empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx <= '0;
            rd_key <= '0;
            rd_vld <= 1'b0;
        end else if (32'(rd_addr) < K) begin
            rd_idx <= idx_q[rd_addr];
            rd_key <= key_q[rd_addr];
            rd_vld <= vld_q[rd_addr];
        end else begin
            rd_idx <= '1;
            rd_key <= '1;
            rd_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_margin_topk.sv
// tb_margin_topk: self-checking bench for margin_topk.
// Three instances share one stimulus stream:
//   u_m0  margin mode, 13-bit index
//   u_m1  least-confidence mode
//   u_i3  margin mode, 3-bit index (overflow cases)
// The reference model keeps every accepted beat of the current run. It
// ranks the samples by a stable sort on the key and compares the first K
// ranks.
module tb_margin_topk;

    localparam int KK = 10;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last;
    logic [63:0] in_scores;
    logic [3:0]  rd_addr;

    logic        busy_a, done_a, err_a, rdy_a, vld_a;
    logic [12:0] idx_a;
    logic [15:0] key_a;
    logic        busy_b, done_b, err_b, rdy_b, vld_b;
    logic [12:0] idx_b;
    logic [15:0] key_b;
    logic        busy_c, done_c, err_c, rdy_c, vld_c;
    logic [2:0]  idx_c;
    logic [15:0] key_c;

    always #5 clk = ~clk;

    margin_topk #(.NUM_CLASSES(4), .SCORE_W(16), .K(10), .IDX_W(13), .MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a), .err(err_a),
        .in_valid(in_valid), .in_ready(rdy_a), .in_last(in_last), .in_scores(in_scores),
        .rd_addr(rd_addr), .rd_idx(idx_a), .rd_key(key_a), .rd_vld(vld_a));

    margin_topk #(.NUM_CLASSES(4), .SCORE_W(16), .K(10), .IDX_W(13), .MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b), .err(err_b),
        .in_valid(in_valid), .in_ready(rdy_b), .in_last(in_last), .in_scores(in_scores),
        .rd_addr(rd_addr), .rd_idx(idx_b), .rd_key(key_b), .rd_vld(vld_b));

    margin_topk #(.NUM_CLASSES(4), .SCORE_W(16), .K(10), .IDX_W(3), .MODE(0)) u_i3 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_c), .done(done_c), .err(err_c),
        .in_valid(in_valid), .in_ready(rdy_c), .in_last(in_last), .in_scores(in_scores),
        .rd_addr(rd_addr), .rd_idx(idx_c), .rd_key(key_c), .rd_vld(vld_c));

    typedef struct { int addr; bit vld; int idx; int key; } rd_vec_t;
    typedef struct { logic [63:0] sc; bit last; } beat_vec_t;

    rd_vec_t     rd_tab [16];
    beat_vec_t   beat_tab [3];
    logic [63:0] run_q [$];
    int          exp_key [3][KK];
    int          exp_idx [3][KK];
    bit          exp_vld [3][KK];
    bit          exp_err [3];
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Key from the rules: max, and the largest of the scores left after
    // removing one copy of the max.
    function automatic int key_of(input logic [63:0] s, input int mode);
        int v [4];
        int mx, mi, sec;
        for (int c = 0; c < 4; c++) v[c] = int'(s[c*16 +: 16]);
        mx = -1;
        mi = 0;
        for (int c = 0; c < 4; c++) if (v[c] > mx) begin mx = v[c]; mi = c; end
        sec = 0;
        for (int c = 0; c < 4; c++) if (c != mi && v[c] > sec) sec = v[c];
        return (mode == 0) ? (mx - sec) : mx;
    endfunction

    // Stable ascending sort by key of the first 2^idx_w samples. On a tie,
    // the lowest index wins.
    function automatic void build_model(input int inst, input int mode, input int idx_w);
        int keys [$];
        int lim, best;
        lim = 1 << idx_w;
        for (int j = 0; j < run_q.size() && j < lim; j++) keys.push_back(key_of(run_q[j], mode));
        for (int r = 0; r < KK; r++) begin
            best = -1;
            for (int j = 0; j < keys.size(); j++)
                if (keys[j] >= 0 && (best < 0 || keys[j] < keys[best])) best = j;
            if (best >= 0) begin
                exp_vld[inst][r] = 1'b1;
                exp_key[inst][r] = keys[best];
                exp_idx[inst][r] = best;
                keys[best] = -1;
            end else begin
                exp_vld[inst][r] = 1'b0;
                exp_key[inst][r] = 65535;
                exp_idx[inst][r] = lim - 1;
            end
        end
        exp_err[inst] = (run_q.size() > lim);
    endfunction

    task automatic check_list(input string tag);
        build_model(0, 0, 13);
        build_model(1, 1, 13);
        build_model(2, 0, 3);
        for (int r = 0; r < KK; r++) begin
            rd_addr = 4'(r);
            tick(1);
            check($sformatf("%s_m0_r%0d", tag, r), {vld_a, idx_a, key_a},
                  {exp_vld[0][r], 13'(exp_idx[0][r]), 16'(exp_key[0][r])});
            check($sformatf("%s_m1_r%0d", tag, r), {vld_b, idx_b, key_b},
                  {exp_vld[1][r], 13'(exp_idx[1][r]), 16'(exp_key[1][r])});
            check($sformatf("%s_i3_r%0d", tag, r), {vld_c, idx_c, key_c},
                  {exp_vld[2][r], 3'(exp_idx[2][r]), 16'(exp_key[2][r])});
        end
        check({tag, "_err_m0"}, err_a, exp_err[0]);
        check({tag, "_err_m1"}, err_b, exp_err[1]);
        check({tag, "_err_i3"}, err_c, exp_err[2]);
    endtask

    task automatic apply_rd_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(rd_tab[i].addr);
            tick(1);
            check($sformatf("%s_a%0d", tag, rd_tab[i].addr), {vld_a, idx_a, key_a},
                  {rd_tab[i].vld, 13'(rd_tab[i].idx), 16'(rd_tab[i].key)});
        end
    endtask

    task automatic send(input logic [63:0] sc, input bit last);
        bit acc;
        acc = 1'b0;
        in_valid  = 1'b1;
        in_scores = sc;
        in_last   = last;
        for (int w = 0; w < 16 && !acc; w++) begin
            acc = rdy_a;
            tick(1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("beat_accept", acc, 1);
        if (acc) run_q.push_back(sc);
    endtask

    task automatic pulse_start(input bit with_beat);
        start = 1'b1;
        if (with_beat) begin
            in_valid  = 1'b1;
            in_last   = 1'b1;
            in_scores = pack4(1, 1, 0, 0);
        end
        tick(1);
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        run_q.delete();
    endtask

    // Called in the cycle after the last beat is accepted.
    task automatic wait_done(input string tag);
        int n;
        n = 1;
        while (!done_a && n < 20) begin
            tick(1);
            n++;
        end
        check({tag, "_done_lat"}, 64'(n), 64'd3);
        check({tag, "_done_i3"}, done_c, 1);
        tick(1);
        check({tag, "_done_pulse"}, {done_a, busy_a}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_done;
        int n;

        // Vector tables.
        for (int i = 0; i < 16; i++) rd_tab[i] = '{i, 1'b0, 'h1FFF, 'hFFFF};
        beat_tab[0] = '{pack4(140, 197, 200, 0), 1'b0};
        beat_tab[1] = '{pack4(14, 200, 200, 0), 1'b0};
        beat_tab[2] = '{pack4(15, 158, 210, 0), 1'b1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_scores = '0; rd_addr = '0;
        tick(3);
        check("rst_rdport", {vld_a, idx_a, key_a}, 0);
        rst = 1'b0;
        tick(2);
        check("rst_status", {rdy_a, busy_a, done_a, err_a}, 0);
        apply_rd_table("reset");

        // Three-beat margin example.
        pulse_start(1'b0);
        for (int i = 0; i < 3; i++) send(beat_tab[i].sc, beat_tab[i].last);
        wait_done("ex3");
        rd_tab[0] = '{0, 1'b1, 1, 0};
        rd_tab[1] = '{1, 1'b1, 0, 3};
        rd_tab[2] = '{2, 1'b1, 2, 52};
        apply_rd_table("ex3");
        check_list("ex3");

        // Beat accepted in cycle t first reads back in cycle t+3.
        rd_addr = 4'd0;
        pulse_start(1'b0);
        send(pack4(10, 4, 0, 0), 1'b0);
        check("vis_t1", vld_a, 0);
        tick(1);
        check("vis_t2", vld_a, 0);
        tick(1);
        check("vis_t3", {vld_a, idx_a, key_a}, {1'b1, 13'd0, 16'd6});
        send(pack4(3, 3, 3, 3), 1'b1);
        wait_done("vis");
        check_list("vis");

        // Least-confidence ranking of 12 descending maxima.
        pulse_start(1'b0);
        for (int i = 0; i < 12; i++) send(pack4(0, 12 - i, 0, 0), i == 11);
        wait_done("lc");
        for (int r = 0; r < KK; r++) begin
            rd_addr = 4'(r);
            tick(1);
            check($sformatf("lc_m1_r%0d", r), {vld_b, idx_b, key_b},
                  {1'b1, 13'(11 - r), 16'(r + 1)});
        end
        check_list("lc");

        // Restart mid-run with a last beat in the same cycle. The restart
        // wins, and older beats, including ones still in the pipe, are gone.
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) send(pack4(9, 9, 0, 0), 1'b0);
        pulse_start(1'b1);
        check("restart_accum", {rdy_a, busy_a}, 2'b11);
        send(pack4(60, 10, 0, 0), 1'b0);
        send(pack4(70, 10, 0, 0), 1'b1);
        wait_done("rs");
        for (int i = 0; i < 16; i++) rd_tab[i] = '{i, 1'b0, 'h1FFF, 'hFFFF};
        rd_tab[0] = '{0, 1'b1, 0, 50};
        rd_tab[1] = '{1, 1'b1, 1, 60};
        apply_rd_table("rs");
        check_list("rs");

        // Index overflow on the 3-bit instance.
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++)
            send(pack4($urandom_range(0, 99), $urandom_range(0, 99), $urandom_range(0, 99), 0), 1'b0);
        check("ovf_before", err_c, 0);
        send(pack4(50, 1, 0, 0), 1'b1);
        check("ovf_after", {err_c, err_a}, 2'b10);
        wait_done("ovf");
        check_list("ovf");

        // Long run with tie ordering.
        pulse_start(1'b0);
        for (int i = 0; i < 5120; i++)
            send((i == 100 || i == 200) ? pack4(5, 5, 0, 0) : pack4(i % 256, 0, 0, 0), i == 5119);
        wait_done("long");
        rd_addr = 4'd0; tick(1); check("long_r0", {idx_a, key_a}, {13'd0, 16'd0});
        rd_addr = 4'd1; tick(1); check("long_r1", {idx_a, key_a}, {13'd100, 16'd0});
        rd_addr = 4'd2; tick(1); check("long_r2", {idx_a, key_a}, {13'd200, 16'd0});
        rd_addr = 4'd3; tick(1); check("long_r3", {idx_a, key_a}, {13'd256, 16'd0});
        check("long_err", err_a, 0);
        check_list("long");

        // Random runs with gaps and many ties.
        for (int run = 0; run < 12; run++) begin
            pulse_start(1'b0);
            n = $urandom_range(1, 20);
            for (int j = 0; j < n; j++) begin
                tick($urandom_range(0, 2));
                send(pack4($urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 15)), j == n - 1);
            end
            wait_done($sformatf("rnd%0d", run));
            check_list($sformatf("rnd%0d", run));
        end

        // Reset mid-run: abandoned, no done pulse, idle until a start.
        pulse_start(1'b0);
        send(pack4(1, 2, 3, 4), 1'b0);
        send(pack4(4, 3, 2, 1), 1'b0);
        #2 rst = 1'b1;
        #1 check("midrst_async", {busy_a, rdy_a, err_a, done_a, vld_a, idx_a, key_a}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_q.delete();
        saw_done = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (done_a) saw_done = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("midrst_no_done", saw_done, 0);
        check("midrst_idle", {busy_a, rdy_a}, 0);
        check_list("midrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/margin_topk.md
MARGIN_TOPK -- requirements
Module: margin_topk

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_CLASSES, 4, class scores per sample, >= 2
- SCORE_W, 16, unsigned score width
- K, 10, number of selected samples, >= 1
- IDX_W, 13, sample index width
- MODE, 0, 0 = margin (max minus second max), 1 = least-confidence (max only)
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst, in, 1, asynchronous active-high reset
- start, in, 1, one-cycle pulse that clears the list and opens a run
- busy, out, 1, run in progress
- done, out, 1, one-cycle pulse when results are final
- err, out, 1, sticky flag for index overflow
- in_valid, in, 1, score beat valid
- in_ready, out, 1, beat accepted when in_valid and in_ready are both high
- in_last, in, 1, last sample of the run
- in_scores, in, NUM_CLASSES*SCORE_W, class c at bits [c*SCORE_W +: SCORE_W]
- rd_addr, in, clog2(K), rank to read; 0 = most uncertain
- rd_idx, out, IDX_W, sample index at that rank
- rd_key, out, SCORE_W, key value at that rank
- rd_vld, out, 1, that rank holds a sample

Function
REQ-003 The block SHALL have four states: IDLE, ACCUM, DRAIN, DONE.
REQ-004 IDLE -> ACCUM on start; this clears all K entries to key = all ones, idx = all ones, vld = 0, and clears the sample counter and err.
REQ-005 A start pulse in any other state SHALL restart the run identically. Beats still in the pipeline at restart SHALL be discarded.
REQ-006 in_ready SHALL be 1 only in ACCUM.
REQ-007 ACCUM -> DRAIN when a beat with in_last = 1 is accepted. DRAIN SHALL last exactly 2 cycles, then move to DONE.
REQ-008 DONE SHALL assert done for 1 cycle, then return to IDLE. busy SHALL be 1 in ACCUM and DRAIN only.
REQ-009 Sample index SHALL be the acceptance order, starting at 0 after each start.
REQ-010 Pipeline stage 1 SHALL register max, second max and index. Second max is the largest of the remaining scores, so duplicate maxima give margin 0.
REQ-011 Key SHALL be max - second (SCORE_W bits, never negative) when MODE = 0, and max when MODE = 1.
REQ-012 Pipeline stage 2 SHALL insert into a K-entry list sorted ascending by key, in one cycle, using parallel compare and shift. The entry at rank K-1 is dropped on overflow.
REQ-013 Insertion SHALL use strict less-than, so equal keys keep the earlier index at the lower rank.
REQ-014 A new key that is not less than a full rank K-1 key SHALL leave the list unchanged.
REQ-015 A beat accepted in cycle t SHALL be visible on the read port from cycle t+3.
REQ-016 Read port: rd_idx, rd_key and rd_vld SHALL be registered, one-cycle latency from rd_addr. An rd_addr >= K SHALL return vld = 0 and all-ones fields.
REQ-017 Readout SHALL be valid in any state; contents SHALL be final from the done pulse until the next start.
REQ-018 Fewer than K samples in a run: the unfilled ranks SHALL keep vld = 0 and all-ones fields.
REQ-019 Index overflow: a beat accepted when the counter equals 2^IDX_W SHALL set err and SHALL NOT be inserted. The counter SHALL saturate. in_last is still honoured.
REQ-020 Simultaneous in_last and start: start wins; the beat is discarded and a new run begins.

Reset
REQ-021 rst asserted SHALL force, asynchronously: state = IDLE; busy, done, err and in_ready = 0; list cleared as in REQ-004; pipeline valid bits = 0; read registers = 0.
REQ-022 Reset mid-run SHALL abandon the run with no done pulse. After reset release, nothing proceeds until a start.

Verification (NUM_CLASSES = 4, SCORE_W = 16, K = 10, IDX_W = 13)
REQ-023 Reset, then read ranks 0 to 9 -> in_ready = 0, busy = 0, every rank vld = 0, idx = 0x1FFF, key = 0xFFFF.
REQ-024 MODE = 0, start, then 3 beats {140,197,200,0}, {14,200,200,0}, {15,158,210,0} with last on beat 3 -> done 3 cycles after the last beat is accepted; rank0 = (idx 1, key 0), rank1 = (idx 0, key 3), rank2 = (idx 2, key 52); ranks 3 to 9 vld = 0.
REQ-025 MODE = 0, start, 5120 beats where beat i = {i%256, 0, 0, 0} and beat 100 = beat 200 = {5,5,0,0} -> rank0 = idx 0 (key 0), rank1 = idx 100, rank2 = idx 200, rank3 = idx 256 (tie ordering); err = 0.
REQ-026 MODE = 1, start, 12 beats with max score = 12 - i -> ranks 0 to 9 = idx 11 down to 2, keys 1 to 10.
REQ-027 Start pulse after 4 beats, then 2 beats with last on the second -> list holds only the 2 new samples (idx 0 and 1); the earlier beats are absent.
REQ-028 IDX_W = 3, 9 beats with last on beat 9 -> err = 1 after beat 9, only 8 entries vld, done still asserted.
